locked_reg_bank: RTL and testbench
==================================

// Module: locked_reg_bank
// PURPOSE
//  Bank of NUM_REGS lockable configuration registers, each DATA_W bits wide, with per-register sticky locks.
//  Once locked, a register can only be written by a trusted debug agent. Every blocked write is reported.
//  Sits between the config bus decoder and security-critical control logic. Replaces single-register locks.
//  Registers hold their value when not written. There is no clear-on-idle.
// PARAMETERS
//  DATA_W     16  width of each register
//  NUM_REGS   4   number of registers (2..256)
//  ADDR_W     2   address width; must satisfy 2**ADDR_W >= NUM_REGS
//  RST_VAL    0   reset value loaded into every register
//  VCNT_W     8   width of the saturating violation counter
// PORTS
//  Clk            in   1                  clock; all logic on rising edge
//  resetn         in   1                  asynchronous, active-low reset
//  wr_en          in   1                  write request
//  wr_addr        in   ADDR_W             write target register
//  wr_data        in   DATA_W             write data
//  lock_req       in   1                  set lock bit of register lock_addr
//  lock_addr      in   ADDR_W             register to lock
//  lock_all       in   1                  set every lock bit
//  debug_mode     in   1                  debug access qualifier
//  trusted        in   1                  trusted-agent qualifier
//  viol_clr       in   1                  clear violation status; honoured only with trusted=1
//  rd_addr        in   ADDR_W             read address
//  rd_data        out  DATA_W             registered read data
//  lock_status    out  NUM_REGS           current lock bits; bit i = register i
//  viol_flag      out  1                  sticky: at least one write was blocked
//  viol_addr      out  ADDR_W             address of the first blocked write since the last clear
//  viol_cnt       out  VCNT_W             saturating count of blocked or illegal writes
// BEHAVIOUR
//  Reset (async, resetn=0): all registers=RST_VAL; lock_status=0; rd_data=0; viol_flag=0; viol_addr=0; viol_cnt=0.
//  Lock bits: set by lock_req (addressed bit) or lock_all (every bit).
//   - Sticky; cleared only by reset. No other input clears a lock bit.
//   - Take effect on the cycle after the request.
//  Write decision, evaluated each cycle with wr_en=1:
//   - wr_addr >= NUM_REGS: write dropped, counted as violation.
//   - Lock bit clear: write accepted.
//   - Lock bit set, debug_mode=1, trusted=1: write accepted.
//   - Lock bit set, any other qualifier combination: write blocked, violation.
//   - debug_mode=1 with trusted=0: the debug qualifier is ignored; the normal rule above applies.
//  Accepted write: register updates on the same edge and is visible on rd_data one cycle later.
//  Lock and write in the same cycle, same address:
//   - The decision uses the lock bit before the edge, so the write lands and the lock applies next cycle.
//  Violation event:
//   - viol_cnt increments, saturating at all-ones.
//   - If viol_flag was 0: viol_flag<=1 and viol_addr<=wr_addr.
//   - If viol_flag was already 1: viol_addr holds the first address.
//  viol_clr with trusted=1: viol_flag, viol_addr and viol_cnt go to 0 on the next edge.
//   - If a violation occurs in the same cycle, clear wins, then the new event is recorded.
//   - Result: viol_flag=1, viol_cnt=1, viol_addr=new address.
//  viol_clr with trusted=0: ignored and not counted.
//  Read: rd_data <= reg[rd_addr] every cycle, 1-cycle latency.
//   - rd_addr >= NUM_REGS returns 0.
//   - Read-during-write to the same address returns the old value.
//  Reset asserted mid-operation: all state returns to reset values immediately.
//   - No write or lock in flight survives reset.
// TESTING
//  T1 reset:
//   - Stimulus: pulse resetn low mid-write.
//   - Response: rd_data=0, lock_status=4'b0000, viol_cnt=0 asynchronously.
//  T2 unlocked write then hold:
//   - Stimulus: write 16'hA5A5 to reg2, then 5 idle cycles.
//   - Response: rd_data(addr2)=16'hA5A5 throughout. No decay to 0.
//  T3 lock blocks write:
//   - Stimulus: lock reg1; write 16'h1234 to reg1.
//   - Response: reg1 unchanged; viol_flag=1, viol_addr=1, viol_cnt=1.
//  T4 trusted debug override:
//   - Stimulus: reg1 locked, debug_mode=1, trusted=1, write 16'hBEEF.
//   - Response: reg1=16'hBEEF; viol_cnt unchanged.
//   - Repeat with trusted=0: response is blocked, viol_cnt+1.
//  T5 same-cycle lock and write:
//   - Stimulus: lock_req and wr_en to reg3 with 16'h0F0F.
//   - Response: reg3=16'h0F0F; the following write is blocked.
//  T6 saturation and clear:
//   - Stimulus: 300 blocked writes with VCNT_W=8.
//   - Response: viol_cnt=8'hFF.
//   - Then viol_clr with trusted=0: no change.
//   - Then viol_clr with trusted=1: viol_cnt=0, viol_flag=0.

Source files
------------

// File: rtl/locked_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : locked_reg_bank
// Purpose  : Bank of lockable configuration registers with sticky per-register
//            locks, trusted-debug override and blocked-write reporting.
// Revision : 1.0 - initial release
// ============================================================================
module locked_reg_bank #(
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 4,
  parameter int                ADDR_W   = 2,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  parameter int                VCNT_W   = 8
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                lock_req,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                lock_all,
  input  logic                debug_mode,
  input  logic                trusted,
  input  logic                viol_clr,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                viol_flag,
  output logic [ADDR_W-1:0]   viol_addr,
  output logic [VCNT_W-1:0]   viol_cnt
);

  localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_viol_flag;
  logic [ADDR_W-1:0]   r_viol_addr;
  logic [VCNT_W-1:0]   r_viol_cnt;

  logic [NUM_REGS-1:0] w_wr_acc;
  logic [NUM_REGS-1:0] w_wr_blk;
  logic [NUM_REGS-1:0] w_lock_set;
  logic [DATA_W-1:0]   w_rd_mux;
  logic                w_dbg_ok;
  logic                w_addr_bad;
  logic                w_viol;
  logic                w_clr;

  // Decisions use the lock bits as they stand before the edge, so a lock
  // requested this cycle only gates writes from the next cycle on.
  always_comb begin
    w_dbg_ok   = debug_mode & trusted;
    w_addr_bad = {1'b0, wr_addr} >= c_num_regs;
    w_wr_acc   = '0;
    w_wr_blk   = '0;
    w_lock_set = '0;
    w_rd_mux   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        w_wr_acc[i] = ~r_lock[i] | w_dbg_ok;
        w_wr_blk[i] = r_lock[i] & ~w_dbg_ok;
      end
      w_lock_set[i] = lock_all | (lock_req && (lock_addr == ADDR_W'(i)));
      if (rd_addr == ADDR_W'(i)) begin
        w_rd_mux = r_regs[i];
      end
    end
    w_viol = wr_en & (w_addr_bad | (|w_wr_blk));
    w_clr  = viol_clr & trusted;
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RST_VAL;
      end
      r_lock    <= '0;
      r_rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_acc[i]) begin
          r_regs[i] <= wr_data;
        end
      end
      r_lock    <= r_lock | w_lock_set;
      r_rd_data <= w_rd_mux;
    end
  end

  // A trusted clear and a new violation in the same cycle leave exactly
  // that one new event recorded.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_viol_flag <= 1'b0;
      r_viol_addr <= '0;
      r_viol_cnt  <= '0;
    end else if (w_clr) begin
      r_viol_flag <= w_viol;
      r_viol_addr <= w_viol ? wr_addr : '0;
      r_viol_cnt  <= w_viol ? VCNT_W'(1) : '0;
    end else if (w_viol) begin
      if (r_viol_cnt != '1) begin
        r_viol_cnt <= r_viol_cnt + VCNT_W'(1);
      end
      if (!r_viol_flag) begin
        r_viol_flag <= 1'b1;
        r_viol_addr <= wr_addr;
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign lock_status = r_lock;
  assign viol_flag   = r_viol_flag;
  assign viol_addr   = r_viol_addr;
  assign viol_cnt    = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_locked_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_locked_reg_bank
// Purpose  : Self-checking bench for locked_reg_bank with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_locked_reg_bank;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        lock_req = 1'b0;
  logic [1:0]  lock_addr = '0;
  logic        lock_all = 1'b0;
  logic        debug_mode = 1'b0;
  logic        trusted = 1'b0;
  logic        viol_clr = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [3:0]  lock_status;
  logic        viol_flag;
  logic [1:0]  viol_addr;
  logic [7:0]  viol_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        rd_req = 1'b0;
  logic [15:0] sb_q [$];
  string       sb_tag [$];

  locked_reg_bank #(
    .DATA_W(16), .NUM_REGS(4), .ADDR_W(2), .RST_VAL(16'h0000), .VCNT_W(8)
  ) dut (
    .Clk(Clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_req(lock_req), .lock_addr(lock_addr), .lock_all(lock_all),
    .debug_mode(debug_mode), .trusted(trusted), .viol_clr(viol_clr),
    .rd_addr(rd_addr), .rd_data(rd_data), .lock_status(lock_status),
    .viol_flag(viol_flag), .viol_addr(viol_addr), .viol_cnt(viol_cnt)
  );

  always #5 Clk = ~Clk;

  // Read scoreboard: a read issued before an edge is checked just after it.
  always @(posedge Clk) begin
    logic v;
    logic [15:0] e;
    string t;
    v = rd_req;
    #1;
    if (v) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: rd_data=%h with no expected value queued", rd_data);
      end else begin
        e = sb_q.pop_front();
        t = sb_tag.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL %s: rd_data=%h expected=%h", t, rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; lock_req = 0; lock_all = 0;
    debug_mode = 0; trusted = 0; viol_clr = 0; rd_req = 0;
  endtask

  task automatic issue_read(input logic [1:0] a, input logic [15:0] e, input string tag);
    rd_addr = a;
    rd_req  = 1;
    sb_q.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    tick();
    do_write(2'd0, 16'h1111);
    lock_all = 1;
    tick();
    lock_all = 0;
    do_write(2'd0, 16'h2222);
    rd_addr = 2'd0;
    tick();
    n_cmp++;
    if (viol_cnt !== 8'd1 || rd_data !== 16'h1111 || lock_status !== 4'hF) begin
      n_err++;
      $display("FAIL pre_reset: cnt=%0d rd=%h lock=%b expected 1/1111/1111", viol_cnt, rd_data, lock_status);
    end
    wr_en = 1; wr_addr = 2'd2; wr_data = 16'h9999; lock_req = 1; lock_addr = 2'd2;
    #2 resetn = 0;
    #1;
    n_cmp++;
    if (rd_data !== 16'h0 || lock_status !== 4'b0000 || viol_cnt !== 8'd0 ||
        viol_flag !== 1'b0 || viol_addr !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: rd=%h lock=%b cnt=%0d flag=%b addr=%0d expected all zero",
               rd_data, lock_status, viol_cnt, viol_flag, viol_addr);
    end
    tick();
    idle();
    #2 resetn = 1;
    tick();
    issue_read(2'd0, 16'h0000, "reg0_after_reset");
    tick();
    issue_read(2'd2, 16'h0000, "reg2_after_reset");
    tick();
    rd_req = 0;
    n_cmp++;
    if (lock_status !== 4'b0000) begin
      n_err++;
      $display("FAIL lock_after_reset: lock=%b expected 0000", lock_status);
    end
  endtask

  task automatic test_write_hold();
    do_write(2'd2, 16'hA5A5);
    for (int i = 0; i < 5; i++) begin
      issue_read(2'd2, 16'hA5A5, "reg2_hold");
      tick();
    end
    wr_en = 1; wr_addr = 2'd2; wr_data = 16'h5A5A;
    issue_read(2'd2, 16'hA5A5, "reg2_rdw_old");
    tick();
    wr_en = 0;
    issue_read(2'd2, 16'h5A5A, "reg2_after_rdw");
    tick();
    rd_req = 0;
  endtask

  task automatic test_lock_block();
    do_write(2'd1, 16'h7777);
    lock_req = 1; lock_addr = 2'd1;
    tick();
    lock_req = 0;
    n_cmp++;
    if (lock_status !== 4'b0010) begin
      n_err++;
      $display("FAIL lock_reg1: lock=%b expected 0010", lock_status);
    end
    do_write(2'd1, 16'h1234);
    n_cmp++;
    if (viol_flag !== 1'b1 || viol_addr !== 2'd1 || viol_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL blocked_write: flag=%b addr=%0d cnt=%0d expected 1/1/1", viol_flag, viol_addr, viol_cnt);
    end
    issue_read(2'd1, 16'h7777, "reg1_unchanged");
    tick();
    rd_req = 0;
  endtask

  task automatic test_debug_override();
    debug_mode = 1; trusted = 1;
    do_write(2'd1, 16'hBEEF);
    n_cmp++;
    if (viol_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL trusted_override_cnt: cnt=%0d expected 1", viol_cnt);
    end
    trusted = 0;
    do_write(2'd1, 16'hCAFE);
    n_cmp++;
    if (viol_cnt !== 8'd2 || viol_addr !== 2'd1) begin
      n_err++;
      $display("FAIL untrusted_debug: cnt=%0d addr=%0d expected 2/1", viol_cnt, viol_addr);
    end
    debug_mode = 0;
    issue_read(2'd1, 16'hBEEF, "reg1_override");
    tick();
    rd_req = 0;
  endtask

  task automatic test_same_cycle_lock();
    lock_req = 1; lock_addr = 2'd3;
    do_write(2'd3, 16'h0F0F);
    lock_req = 0;
    n_cmp++;
    if (lock_status !== 4'b1010 || viol_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL same_cycle_lock: lock=%b cnt=%0d expected 1010/2", lock_status, viol_cnt);
    end
    do_write(2'd3, 16'hF0F0);
    n_cmp++;
    if (viol_cnt !== 8'd3 || viol_addr !== 2'd1) begin
      n_err++;
      $display("FAIL after_lock_write: cnt=%0d addr=%0d expected 3/1", viol_cnt, viol_addr);
    end
    issue_read(2'd3, 16'h0F0F, "reg3_same_cycle");
    tick();
    rd_req = 0;
  endtask

  task automatic test_clear_race();
    viol_clr = 1; trusted = 1;
    do_write(2'd3, 16'h3333);
    viol_clr = 0; trusted = 0;
    n_cmp++;
    if (viol_flag !== 1'b1 || viol_cnt !== 8'd1 || viol_addr !== 2'd3) begin
      n_err++;
      $display("FAIL clear_race: flag=%b cnt=%0d addr=%0d expected 1/1/3", viol_flag, viol_cnt, viol_addr);
    end
  endtask

  task automatic test_saturation();
    viol_clr = 1; trusted = 1;
    tick();
    viol_clr = 0; trusted = 0;
    n_cmp++;
    if (viol_flag !== 1'b0 || viol_cnt !== 8'd0 || viol_addr !== 2'd0) begin
      n_err++;
      $display("FAIL clear_idle: flag=%b cnt=%0d addr=%0d expected 0/0/0", viol_flag, viol_cnt, viol_addr);
    end
    for (int i = 0; i < 300; i++) begin
      do_write((i % 2 == 0) ? 2'd1 : 2'd3, 16'(i));
      if (i == 253) begin
        n_cmp++;
        if (viol_cnt !== 8'd254) begin
          n_err++;
          $display("FAIL cnt_254: cnt=%0d expected 254", viol_cnt);
        end
      end
    end
    n_cmp++;
    if (viol_cnt !== 8'hFF || viol_flag !== 1'b1 || viol_addr !== 2'd1) begin
      n_err++;
      $display("FAIL saturate: cnt=%h flag=%b addr=%0d expected ff/1/1", viol_cnt, viol_flag, viol_addr);
    end
    viol_clr = 1; trusted = 0;
    tick();
    n_cmp++;
    if (viol_cnt !== 8'hFF || viol_flag !== 1'b1) begin
      n_err++;
      $display("FAIL untrusted_clr: cnt=%h flag=%b expected ff/1", viol_cnt, viol_flag);
    end
    trusted = 1;
    tick();
    viol_clr = 0; trusted = 0;
    n_cmp++;
    if (viol_cnt !== 8'd0 || viol_flag !== 1'b0) begin
      n_err++;
      $display("FAIL trusted_clr: cnt=%h flag=%b expected 00/0", viol_cnt, viol_flag);
    end
    issue_read(2'd1, 16'hBEEF, "reg1_after_sat");
    tick();
    rd_req = 0;
  endtask

  task automatic test_lock_all();
    lock_all = 1;
    tick();
    lock_all = 0;
    n_cmp++;
    if (lock_status !== 4'b1111) begin
      n_err++;
      $display("FAIL lock_all: lock=%b expected 1111", lock_status);
    end
    do_write(2'd0, 16'hDEAD);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (viol_cnt !== 8'd1 || viol_addr !== 2'd0 || lock_status !== 4'b1111) begin
      n_err++;
      $display("FAIL lock_all_block: cnt=%0d addr=%0d lock=%b expected 1/0/1111", viol_cnt, viol_addr, lock_status);
    end
    issue_read(2'd0, 16'h0000, "reg0_locked");
    tick();
    issue_read(2'd2, 16'h5A5A, "reg2_final");
    tick();
    rd_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_hold();
    test_lock_block();
    test_debug_override();
    test_same_cycle_lock();
    test_clear_race();
    test_saturation();
    test_lock_all();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d reads left unchecked, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
